io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Target-side end of the processor's memory-mapped bus. Consumes ADDR/DOUT/W driven by proc and returns read data on DIN.
- Decodes ADDR[15:12] into four regions: RAM pass-through, LED output register, synchronised switch input port, and a programmable down-count timer.
- Replaces the standalone chip-select decode plus LED register; sits between proc, the wram instance and board I/O.

Parameters:
- TIMER_W, 16, timer LOAD/COUNT width (2..16); zero-extended to 16 bits on read.
- SYNC_STAGES, 2, flop stages on the SW input (>=2).

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- ADDR  in  16  bus address from proc, registered at source.
- DOUT  in  16  write data from proc.
- W  in  1  write strobe; a write occurs in each cycle W=1.
- DIN  out  16  read data to proc; one-cycle latency.
- MEM_Q  in  16  wram registered read data.
- MEM_WREN  out  1  wram write enable.
- SW  in  16  asynchronous board switches.
- LED  out  16  LED register.

Behaviour:
- Region = ADDR[15:12]: 0 RAM, 1 LED, 2 SW, 3 timer; 4..F unmapped (reads 0x0000, writes ignored).
- MEM_WREN = W & (region==0), combinational. No other region touches RAM.
- LED: W & region 1 -> LED <= DOUT next edge. Reads return LED.
- SW: SYNC_STAGES-deep synchroniser; reads return the last stage.
- Timer sub-register = ADDR[1:0]:
  - 0 LOAD: R/W. A write also sets COUNT <= DOUT[TIMER_W-1:0].
  - 1 COUNT: read-only; writes ignored.
  - 2 CTRL: R/W; bit0 EN, bit1 RELOAD; other bits read 0.
  - 3 STATUS: bit0 EXPIRED (sticky); any write clears it.
- Timer per cycle, when EN=1:
  - COUNT!=0: COUNT-1. On the 1->0 step, EXPIRED <= 1.
  - COUNT==0 and RELOAD=1: COUNT <= LOAD.
  - COUNT==0 and RELOAD=0: EN <= 0, COUNT holds 0.
  - EN=0: COUNT holds.
- Timer collisions:
  - LOAD write same cycle as decrement/reload: write wins.
  - CTRL write same cycle as auto-clear of EN: write wins.
  - EXPIRED set and STATUS write in same cycle: set wins.
- Read latency:
  - Region and sub-address are registered each cycle.
  - Non-RAM read data is registered each cycle from current ADDR, so DIN reflects the ADDR of the previous cycle.
  - If the registered region is 0, DIN = MEM_Q (same one-cycle latency as wram); otherwise DIN = registered peripheral data.
- Read-during-write to the same peripheral register returns the old value.
- Reset asserted (any time, including mid-count):
  - LED, DIN, LOAD, COUNT, CTRL, STATUS, registered region and sync chain -> 0 immediately.
  - MEM_WREN forced 0.
- Timer arithmetic: modulo 2^TIMER_W; no underflow below 0.

Optional Feature:
- Macro: IO_RESPONDER_IRQ_EN.
- Defined:
  - Adds output IRQ (1 bit), registered: IRQ = EXPIRED & CTRL bit2 (IE).
  - CTRL bit2 becomes R/W; IRQ is 0 on reset.
  - IRQ drops the cycle after EXPIRED is cleared.
- Undefined: no IRQ port; CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Reset then ADDR=0x1000, DOUT=0xA5A5, W=1 for one cycle -> LED=0xA5A5 next edge, MEM_WREN=0. Read 0x1000 -> DIN=0xA5A5 one cycle later.
- W=1, ADDR=0x0004 -> MEM_WREN=1 that cycle. Read 0x0004 with MEM_Q=0x1234 -> DIN=0x1234 next cycle.
- SW=0x00F0 held -> read 0x2000 returns 0x00F0 only after SYNC_STAGES+1 cycles, 0x0000 before. Read 0x5000 -> 0x0000.
- Write LOAD=3, CTRL=0x1 -> COUNT 3,2,1,0; EXPIRED=1; EN auto-clears; COUNT stays 0. Write STATUS -> EXPIRED=0.
- LOAD=2, CTRL=0x3 -> COUNT 2,1,0,2,1,0 repeating; EXPIRED set at first 0. A STATUS write coinciding with the next 1->0 step leaves EXPIRED=1.
- Reset asserted mid-count with COUNT=5 -> COUNT, CTRL, LED, DIN read 0 before the next clock edge. With IO_RESPONDER_IRQ_EN: CTRL=0x5, LOAD=1 -> IRQ=1 after expiry, 0 after STATUS write.

Source files
------------

// File: rtl/io_responder.sv
// Bus target for proc: decodes ADDR[15:12] into RAM, LED, switch and timer regions.
// Build option IO_RESPONDER_IRQ_EN adds the IRQ output and the CTRL interrupt-enable bit.
module io_responder #(
  parameter int TIMER_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [15:0] MEM_Q,
  output logic        MEM_WREN,
  input  logic [15:0] SW,
  output logic [15:0] LED
`ifdef IO_RESPONDER_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam logic [3:0] REG_RAM   = 4'h0;
  localparam logic [3:0] REG_LED   = 4'h1;
  localparam logic [3:0] REG_SW    = 4'h2;
  localparam logic [3:0] REG_TIMER = 4'h3;

  localparam logic [1:0] SUB_LOAD   = 2'd0;
  localparam logic [1:0] SUB_COUNT  = 2'd1;
  localparam logic [1:0] SUB_CTRL   = 2'd2;
  localparam logic [1:0] SUB_STATUS = 2'd3;

  logic [3:0]                    w_region;
  logic [1:0]                    w_sub;
  logic                          w_led_wr;
  logic                          w_load_wr;
  logic                          w_ctrl_wr;
  logic                          w_status_wr;
  logic                          w_expire;
  logic                          w_ie;
  logic [15:0]                   w_rdata;
  logic                          w_unused;

  logic [3:0]                    r_region;
  logic [15:0]                   r_rdata;
  logic [15:0]                   r_led;
  logic [SYNC_STAGES-1:0][15:0]  r_sync;
  logic [TIMER_W-1:0]            r_load;
  logic [TIMER_W-1:0]            r_count;
  logic                          r_en;
  logic                          r_reload;
  logic                          r_expired;

  assign w_region    = ADDR[15:12];
  assign w_sub       = ADDR[1:0];
  assign w_led_wr    = W & (w_region == REG_LED);
  assign w_load_wr   = W & (w_region == REG_TIMER) & (w_sub == SUB_LOAD);
  assign w_ctrl_wr   = W & (w_region == REG_TIMER) & (w_sub == SUB_CTRL);
  assign w_status_wr = W & (w_region == REG_TIMER) & (w_sub == SUB_STATUS);
  assign w_expire    = r_en & (r_count == TIMER_W'(1));
  assign w_unused    = &{1'b0, ADDR[11:2]};

  // RAM write strobe is combinational so wram sees it in the same cycle as W.
  assign MEM_WREN = W & (w_region == REG_RAM) & ~Reset;
  assign LED      = r_led;
  // Region 0 passes wram's own registered data; held at zero while in reset.
  assign DIN      = Reset ? 16'h0000 : ((r_region == REG_RAM) ? MEM_Q : r_rdata);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_led <= 16'h0000;
    end else if (w_led_wr) begin
      r_led <= DOUT;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync <= {(SYNC_STAGES*16){1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], SW};
    end
  end

  // Autonomous counting first; bus writes later in the block take priority.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_load    <= {TIMER_W{1'b0}};
      r_count   <= {TIMER_W{1'b0}};
      r_en      <= 1'b0;
      r_reload  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      if (r_en) begin
        if (r_count != {TIMER_W{1'b0}}) begin
          r_count <= r_count - TIMER_W'(1);
        end else if (r_reload) begin
          r_count <= r_load;
        end else begin
          r_en <= 1'b0;
        end
      end
      if (w_status_wr) begin
        r_expired <= 1'b0;
      end
      if (w_expire) begin
        r_expired <= 1'b1;
      end
      if (w_load_wr) begin
        r_load  <= DOUT[TIMER_W-1:0];
        r_count <= DOUT[TIMER_W-1:0];
      end
      if (w_ctrl_wr) begin
        r_en     <= DOUT[0];
        r_reload <= DOUT[1];
      end
    end
  end

`ifdef IO_RESPONDER_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_ie <= DOUT[2];
      end
      r_irq <= r_expired & r_ie;
    end
  end

  assign w_ie = r_ie;
  assign IRQ  = r_irq;
`else
  assign w_ie = 1'b0;
`endif

  // Read data is computed from the current address against pre-edge state.
  always_comb begin
    w_rdata = 16'h0000;
    case (w_region)
      REG_LED: w_rdata = r_led;
      REG_SW:  w_rdata = r_sync[SYNC_STAGES-1];
      REG_TIMER: begin
        case (w_sub)
          SUB_LOAD:   w_rdata = 16'(r_load);
          SUB_COUNT:  w_rdata = 16'(r_count);
          SUB_CTRL:   w_rdata = {13'h0000, w_ie, r_reload, r_en};
          SUB_STATUS: w_rdata = {15'h0000, r_expired};
          default:    w_rdata = 16'h0000;
        endcase
      end
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_region <= 4'h0;
      r_rdata  <= 16'h0000;
    end else begin
      r_region <= w_region;
      r_rdata  <= w_rdata;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder (default build; IRQ test when IO_RESPONDER_IRQ_EN is defined).
module tb_io_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic [15:0] MEM_Q;
  logic        MEM_WREN;
  logic [15:0] SW;
  logic [15:0] LED;
`ifdef IO_RESPONDER_IRQ_EN
  logic        IRQ;
`endif

  int errors = 0;
  int checks = 0;

  io_responder #(.TIMER_W(16), .SYNC_STAGES(2)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ADDR     (ADDR),
    .DOUT     (DOUT),
    .W        (W),
    .DIN      (DIN),
    .MEM_Q    (MEM_Q),
    .MEM_WREN (MEM_WREN),
    .SW       (SW),
    .LED      (LED)
`ifdef IO_RESPONDER_IRQ_EN
    ,
    .IRQ      (IRQ)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; DOUT = d; W = 1'b1;
    cyc();
    W = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] q);
    ADDR = a; W = 1'b0;
    cyc();
    q = DIN;
  endtask

  task automatic test_reset();
    Reset = 1'b1; W = 1'b1; ADDR = 16'h0000; DOUT = 16'hFFFF;
    MEM_Q = 16'hBEEF; SW = 16'h0000;
    cyc(); cyc();
    checks++; if (LED !== 16'h0000) begin errors++; $display("FAIL reset_led got=%h exp=%h", LED, 16'h0000); end
    checks++; if (DIN !== 16'h0000) begin errors++; $display("FAIL reset_din got=%h exp=%h", DIN, 16'h0000); end
    checks++; if (MEM_WREN !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", MEM_WREN); end
    W = 1'b0; Reset = 1'b0;
    cyc();
  endtask

  task automatic test_led();
    logic [15:0] q;
    ADDR = 16'h1000; DOUT = 16'hA5A5; W = 1'b1;
    #1;
    checks++; if (MEM_WREN !== 1'b0) begin errors++; $display("FAIL led_wren got=%b exp=0", MEM_WREN); end
    cyc(); W = 1'b0;
    checks++; if (LED !== 16'hA5A5) begin errors++; $display("FAIL led_port got=%h exp=%h", LED, 16'hA5A5); end
    rd(16'h1000, q);
    checks++; if (q !== 16'hA5A5) begin errors++; $display("FAIL led_read got=%h exp=%h", q, 16'hA5A5); end
    wr(16'h1000, 16'h5A5A);
    checks++; if (DIN !== 16'hA5A5) begin errors++; $display("FAIL led_rdw got=%h exp=%h", DIN, 16'hA5A5); end
    checks++; if (LED !== 16'h5A5A) begin errors++; $display("FAIL led_port2 got=%h exp=%h", LED, 16'h5A5A); end
  endtask

  task automatic test_ram();
    logic [15:0] q;
    ADDR = 16'h0004; DOUT = 16'h1111; W = 1'b1;
    #1;
    checks++; if (MEM_WREN !== 1'b1) begin errors++; $display("FAIL ram_wren got=%b exp=1", MEM_WREN); end
    cyc(); W = 1'b0;
    MEM_Q = 16'h1234;
    rd(16'h0004, q);
    checks++; if (q !== 16'h1234) begin errors++; $display("FAIL ram_read got=%h exp=%h", q, 16'h1234); end
    checks++; if (MEM_WREN !== 1'b0) begin errors++; $display("FAIL ram_wren_idle got=%b exp=0", MEM_WREN); end
  endtask

  task automatic test_sw_unmapped();
    logic [15:0] q;
    logic [15:0] exp_sw [3] = '{16'h0000, 16'h0000, 16'h00F0};
    ADDR = 16'h2000; W = 1'b0; SW = 16'h00F0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (DIN !== exp_sw[i]) begin errors++; $display("FAIL sw_sync[%0d] got=%h exp=%h", i, DIN, exp_sw[i]); end
    end
    ADDR = 16'h5000; DOUT = 16'hFFFF; W = 1'b1;
    #1;
    checks++; if (MEM_WREN !== 1'b0) begin errors++; $display("FAIL unmapped_wren got=%b exp=0", MEM_WREN); end
    cyc(); W = 1'b0;
    checks++; if (LED !== 16'h5A5A) begin errors++; $display("FAIL unmapped_led got=%h exp=%h", LED, 16'h5A5A); end
    rd(16'h5000, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", q, 16'h0000); end
  endtask

  task automatic test_timer_oneshot();
    logic [15:0] q;
    logic [15:0] exp_cnt [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
    wr(16'h3000, 16'd3);
    wr(16'h3002, 16'h0001);
    ADDR = 16'h3001; W = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (DIN !== exp_cnt[i]) begin errors++; $display("FAIL oneshot_count[%0d] got=%h exp=%h", i, DIN, exp_cnt[i]); end
    end
    rd(16'h3002, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL oneshot_en_clear got=%h exp=%h", q, 16'h0000); end
    rd(16'h3001, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL oneshot_hold0 got=%h exp=%h", q, 16'h0000); end
    rd(16'h3003, q);
    checks++; if (q !== 16'h0001) begin errors++; $display("FAIL oneshot_expired got=%h exp=%h", q, 16'h0001); end
    wr(16'h3003, 16'h0000);
    rd(16'h3003, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL oneshot_status_clr got=%h exp=%h", q, 16'h0000); end
  endtask

  task automatic test_timer_reload();
    logic [15:0] q;
    logic [15:0] exp_cnt [6] = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0};
    wr(16'h3000, 16'd2);
    wr(16'h3002, 16'h0003);
    ADDR = 16'h3001; W = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (DIN !== exp_cnt[i]) begin errors++; $display("FAIL reload_count[%0d] got=%h exp=%h", i, DIN, exp_cnt[i]); end
    end
    // Count is now 2: this clear lands on the 2->1 step.
    wr(16'h3003, 16'h0000);
    checks++; if (DIN !== 16'h0001) begin errors++; $display("FAIL reload_expired_set got=%h exp=%h", DIN, 16'h0001); end
    // This clear coincides with the 1->0 step, so the set must win.
    wr(16'h3003, 16'h0000);
    checks++; if (DIN !== 16'h0000) begin errors++; $display("FAIL reload_status_clr got=%h exp=%h", DIN, 16'h0000); end
    wr(16'h3002, 16'h0000);
    checks++; if (DIN !== 16'h0003) begin errors++; $display("FAIL reload_ctrl_read got=%h exp=%h", DIN, 16'h0003); end
    rd(16'h3003, q);
    checks++; if (q !== 16'h0001) begin errors++; $display("FAIL reload_set_wins got=%h exp=%h", q, 16'h0001); end
    rd(16'h3001, q);
    checks++; if (q !== 16'h0002) begin errors++; $display("FAIL reload_stop_count got=%h exp=%h", q, 16'h0002); end
    rd(16'h3000, q);
    checks++; if (q !== 16'h0002) begin errors++; $display("FAIL reload_load_read got=%h exp=%h", q, 16'h0002); end
    wr(16'h3003, 16'h0000);
  endtask

  task automatic test_ctrl_bits();
    logic [15:0] q;
    logic [15:0] exp_ctrl;
`ifdef IO_RESPONDER_IRQ_EN
    exp_ctrl = 16'h0006;
`else
    exp_ctrl = 16'h0002;
`endif
    wr(16'h3002, 16'hFFFE & 16'h0006 | 16'hFFF8);
    rd(16'h3002, q);
    checks++; if (q !== exp_ctrl) begin errors++; $display("FAIL ctrl_bits got=%h exp=%h", q, exp_ctrl); end
    wr(16'h3001, 16'h7777);
    rd(16'h3001, q);
    checks++; if (q !== 16'h0002) begin errors++; $display("FAIL count_readonly got=%h exp=%h", q, 16'h0002); end
    wr(16'h3002, 16'h0000);
  endtask

`ifdef IO_RESPONDER_IRQ_EN
  task automatic test_irq();
    wr(16'h3000, 16'd1);
    wr(16'h3002, 16'h0005);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", IRQ); end
    ADDR = 16'h0000; W = 1'b0;
    cyc(); cyc();
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", IRQ); end
    wr(16'h3003, 16'h0000);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_lag got=%b exp=1", IRQ); end
    cyc();
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=0", IRQ); end
    wr(16'h3002, 16'h0000);
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] q;
    wr(16'h3000, 16'd6);
    wr(16'h3002, 16'h0001);
    rd(16'h1000, q);
    checks++; if (q !== 16'h5A5A) begin errors++; $display("FAIL mid_pre_led got=%h exp=%h", q, 16'h5A5A); end
    Reset = 1'b1; W = 1'b1; ADDR = 16'h0000;
    #1;
    checks++; if (LED !== 16'h0000) begin errors++; $display("FAIL mid_led got=%h exp=%h", LED, 16'h0000); end
    checks++; if (DIN !== 16'h0000) begin errors++; $display("FAIL mid_din got=%h exp=%h", DIN, 16'h0000); end
    checks++; if (MEM_WREN !== 1'b0) begin errors++; $display("FAIL mid_wren got=%b exp=0", MEM_WREN); end
    cyc();
    W = 1'b0; Reset = 1'b0;
    rd(16'h3001, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL mid_count got=%h exp=%h", q, 16'h0000); end
    rd(16'h3002, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL mid_ctrl got=%h exp=%h", q, 16'h0000); end
    rd(16'h3000, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL mid_load got=%h exp=%h", q, 16'h0000); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_ram();
    test_sw_unmapped();
    test_timer_oneshot();
    test_timer_reload();
    test_ctrl_bits();
`ifdef IO_RESPONDER_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
